ysyx_22050078_imem: RTL

YSYX_22050078_IMEM -- requirements
Module: ysyx_22050078_imem

---
 rtl/ysyx_22050078_imem.sv | 119 +++++++++++
 1 files changed

// File: rtl/ysyx_22050078_imem.sv
// Instruction memory with a valid/ready fetch port, fixed response latency and
// a program-load write port. Misaligned or out-of-range fetches respond with an error.
module ysyx_22050078_imem #(
   parameter int unsigned  DEPTH      = 1024,
   parameter int unsigned  LATENCY    = 2,          // legal range 1..15
   parameter logic [63:0]  BASE_ADDR  = 64'h8000_0000,
   localparam int unsigned CPU_WIDTH  = 64,
   localparam int unsigned INST_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [CPU_WIDTH-1:0]  req_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [INST_WIDTH-1:0] rsp_inst,
   output logic                  rsp_err,
   input  logic                  wr_en,
   input  logic [CPU_WIDTH-1:0]  wr_addr,
   input  logic [INST_WIDTH-1:0] wr_data
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CPU_WIDTH-1:0]  addr_q, addr_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic                  err_q, err_d;
   logic                  ready_q, ready_d;
   logic                  valid_q, valid_d;

   logic [INST_WIDTH-1:0] mem [DEPTH];

   // Word index is taken modulo 2^64, so addresses below the base wrap to a huge index.
   logic [CPU_WIDTH-1:0]  rd_word, wr_word;
   logic                  rd_bad, wr_bad;

   assign rd_word = (addr_q - BASE_ADDR) >> 2;
   assign rd_bad  = (addr_q[1:0] != 2'b00) || (rd_word >= CPU_WIDTH'(DEPTH));
   assign wr_word = (wr_addr - BASE_ADDR) >> 2;
   assign wr_bad  = (wr_addr[1:0] != 2'b00) || (wr_word >= CPU_WIDTH'(DEPTH));

   // Program-load port; not reset so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (wr_en && !wr_bad) begin
         mem[wr_word[IDX_W-1:0]] <= wr_data;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      inst_d  = inst_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               // Reads the pre-edge word, so a same-edge write is not seen.
               err_d   = rd_bad;
               inst_d  = rd_bad ? '0 : mem[rd_word[IDX_W-1:0]];
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
      valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         inst_q  <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = valid_q;
   assign rsp_inst  = inst_q;
   assign rsp_err   = err_q;

endmodule
